// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: WIDTH-bit add split into STAGE_W-bit slices, one register stage per slice.
// Optional signed saturation of s on overflow when PIPELINED_ADDSUB_SAT_EN is defined.
module pipelined_addsub #(
    parameter int WIDTH   = 32,
    parameter int STAGE_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    cin,
    input  logic                    sign,
    input  logic                    comp_e,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] s,
    output logic                    cout,
    output logic                    cout_1,
    output logic                    ovf
);
    localparam int NSTG = WIDTH / STAGE_W;

    logic             en;
    logic             accept;
    logic [WIDTH-1:0] xb_in;
    logic             c0;

    // The whole pipe freezes only when a finished result is waiting on the consumer.
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;
    assign accept   = in_valid && en;
    assign xb_in    = b ^ {WIDTH{sign}};
    assign c0       = comp_e ? sign : cin;

`ifdef PIPELINED_ADDSUB_SAT_EN
    function automatic logic [WIDTH-1:0] sat_result(input logic [WIDTH-1:0] raw,
                                                    input logic             v,
                                                    input logic             amsb);
        if (v)
            return amsb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return raw;
    endfunction
`endif

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int LO = k * STAGE_W;
        localparam int UP = LO + STAGE_W;

        logic [STAGE_W-1:0] a_sl;
        logic [STAGE_W-1:0] b_sl;
        logic               c_in;
        logic               v_in;
        logic [UP-1:0]      sum_d;
        logic [STAGE_W:0]   add;
        logic               vld_p;
        logic               cy_p;
        logic [UP-1:0]      sum_p;

        // Stage boundary: slice k of the operands enters from the inputs or the previous stage's skew registers.
        if (k == 0) begin : g_src
            assign a_sl  = a[STAGE_W-1:0];
            assign b_sl  = xb_in[STAGE_W-1:0];
            assign c_in  = c0;
            assign v_in  = accept;
            assign sum_d = add[STAGE_W-1:0];
        end else begin : g_src
            assign a_sl  = g_stg[k-1].g_hi.a_hi_p[STAGE_W-1:0];
            assign b_sl  = g_stg[k-1].g_hi.xb_hi_p[STAGE_W-1:0];
            assign c_in  = g_stg[k-1].cy_p;
            assign v_in  = g_stg[k-1].vld_p;
            assign sum_d = {add[STAGE_W-1:0], g_stg[k-1].sum_p};
        end

        assign add = {1'b0, a_sl} + {1'b0, b_sl} + {{STAGE_W{1'b0}}, c_in};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                vld_p <= 1'b0;
            else if (en)
                vld_p <= v_in;
        end

        if (k < NSTG - 1) begin : g_hi
            logic [WIDTH-UP-1:0] a_hi_d;
            logic [WIDTH-UP-1:0] xb_hi_d;
            logic [WIDTH-UP-1:0] a_hi_p;
            logic [WIDTH-UP-1:0] xb_hi_p;

            if (k == 0) begin : g_hsrc
                assign a_hi_d  = a[WIDTH-1:UP];
                assign xb_hi_d = xb_in[WIDTH-1:UP];
            end else begin : g_hsrc
                assign a_hi_d  = g_stg[k-1].g_hi.a_hi_p[WIDTH-LO-1:STAGE_W];
                assign xb_hi_d = g_stg[k-1].g_hi.xb_hi_p[WIDTH-LO-1:STAGE_W];
            end

            always_ff @(posedge clk) begin
                if (en) begin
                    a_hi_p  <= a_hi_d;
                    xb_hi_p <= xb_hi_d;
                    sum_p   <= sum_d;
                    cy_p    <= add[STAGE_W];
                end
            end
        end else begin : g_last
            logic c1_d;
            logic c1_p;
`ifdef PIPELINED_ADDSUB_SAT_EN
            logic amsb_p;
`endif
            // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
            assign c1_d = add[STAGE_W-1] ^ a_sl[STAGE_W-1] ^ b_sl[STAGE_W-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_p  <= '0;
                    cy_p   <= 1'b0;
                    c1_p   <= 1'b0;
`ifdef PIPELINED_ADDSUB_SAT_EN
                    amsb_p <= 1'b0;
`endif
                end else if (en) begin
                    sum_p  <= sum_d;
                    cy_p   <= add[STAGE_W];
                    c1_p   <= c1_d;
`ifdef PIPELINED_ADDSUB_SAT_EN
                    amsb_p <= a_sl[STAGE_W-1];
`endif
                end
            end
        end
    end

    assign out_valid = g_stg[NSTG-1].vld_p;
    assign cout      = g_stg[NSTG-1].cy_p;
    assign cout_1    = g_stg[NSTG-1].g_last.c1_p;
    assign ovf       = cout ^ cout_1;
`ifdef PIPELINED_ADDSUB_SAT_EN
    assign s = sat_result(g_stg[NSTG-1].sum_p, ovf, g_stg[NSTG-1].g_last.amsb_p);
`else
    assign s = g_stg[NSTG-1].sum_p;
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub (WIDTH=32, STAGE_W=16): directed vectors plus an arithmetic scoreboard model.
module tb_pipelined_addsub;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [31:0] a = '0;
    logic signed [31:0] b = '0;
    logic               cin = 1'b0;
    logic               sign = 1'b0;
    logic               comp_e = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [31:0] s;
    logic               cout;
    logic               cout_1;
    logic               ovf;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pop = 0;

    // Expected result record: {ovf, cout_1, cout, s}
    logic [34:0] exp_q[$];

    pipelined_addsub #(.WIDTH(32), .STAGE_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sign(sign), .comp_e(comp_e),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .cout_1(cout_1), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [34:0] model(input logic [31:0] ia, input logic [31:0] ib,
                                          input logic isg, input logic icmp, input logic icin);
        logic [31:0] xb;
        logic [63:0] full;
        logic        co, sv, c1;
        logic [31:0] rs;
        xb   = isg ? ~ib : ib;
        full = {32'd0, ia} + {32'd0, xb} + {63'd0, (icmp ? isg : icin)};
        co   = full[32];
        rs   = full[31:0];
        sv   = (ia[31] == xb[31]) && (rs[31] != ia[31]);
        c1   = sv ^ co;
`ifdef PIPELINED_ADDSUB_SAT_EN
        if (sv) rs = ia[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return {sv, c1, co, rs};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard bookkeeping on the active edge (values seen before the edge).
    always @(posedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL pop_unexpected: got out_valid=1 expected no pending result");
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(a, b, sign, comp_e, cin));
        end
    end

    always @(negedge rst_n) exp_q.delete();

    // Compare process: every cycle the outputs are meaningful.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready_rule", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL spurious_valid: got out_valid=1 expected 0");
                end else begin
                    chk("sb_s",      s,                  exp_q[0][31:0]);
                    chk("sb_flags",  {29'd0, ovf, cout_1, cout}, {29'd0, exp_q[0][34:32]});
                end
            end
        end
    end

    task automatic drive(input logic [31:0] ia, input logic [31:0] ib,
                         input logic isg, input logic icmp, input logic icin);
        a = ia; b = ib; sign = isg; comp_e = icmp; cin = icin; in_valid = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_chk(input string nm, input logic [31:0] ia, input logic [31:0] ib,
                            input logic isg, input logic icmp, input logic icin,
                            input logic [31:0] es, input logic ec, input logic ec1, input logic eo);
        drive(ia, ib, isg, icmp, icin);
        tick();
        in_valid = 1'b0;
        chk({nm, "_lat1"}, {31'd0, out_valid}, 32'd0);
        tick();
        chk({nm, "_lat2"}, {31'd0, out_valid}, 32'd1);
        chk({nm, "_s"}, s, es);
        chk({nm, "_cout"}, {31'd0, cout}, {31'd0, ec});
        chk({nm, "_cout1"}, {31'd0, cout_1}, {31'd0, ec1});
        chk({nm, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] va [4];
        logic [31:0] vb [4];
        int          pop0;
        va = '{32'h1234_5678, 32'hFFFF_0001, 32'h8000_0000, 32'h0F0F_F0F0};
        vb = '{32'h1111_1111, 32'h0000_FFFF, 32'h0000_0001, 32'h7070_0F10};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_s", s, 32'd0);
        chk("rst_flags", {29'd0, ovf, cout_1, cout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        send_chk("carry", 32'h0000_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        send_chk("sub_neg", 32'd5, 32'd7, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        send_chk("sub_pos", 32'd7, 32'd5, 1'b1, 1'b1, 1'b0, 32'd2, 1'b1, 1'b1, 1'b0);
        send_chk("ones_cmp", 32'd10, 32'd3, 1'b1, 1'b0, 1'b0, 32'd6, 1'b1, 1'b1, 1'b0);
        send_chk("cin_add", 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b1, 1'b1, 1'b0);
`ifdef PIPELINED_ADDSUB_SAT_EN
        send_chk("ovf_pos", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
        send_chk("ovf_neg", 32'h8000_0000, 32'd1, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
`else
        send_chk("ovf_pos", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
        send_chk("ovf_neg", 32'h8000_0000, 32'd1, 1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);
`endif

        // Backpressure: four back-to-back transactions, consumer stalls after the first result.
        pop0 = n_pop;
        drive(va[0], vb[0], 1'b0, 1'b0, 1'b0);
        tick();
        drive(va[1], vb[1], 1'b1, 1'b1, 1'b0);
        tick();
        chk("bp_first_s", s, 32'h2345_6789);
        out_ready = 1'b0;
        drive(va[2], vb[2], 1'b1, 1'b0, 1'b1);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_s", s, 32'h2345_6789);
            tick();
        end
        out_ready = 1'b1;
        tick();
        drive(va[3], vb[3], 1'b0, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("bp_pop_count", n_pop - pop0, 32'd4);
        chk("bp_drained", exp_q.size(), 32'd0);

        // Reset with two transactions in flight.
        drive(32'd100, 32'd200, 1'b0, 1'b0, 1'b0);
        tick();
        drive(32'd300, 32'd400, 1'b0, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("mid_valid_before", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_s", s, 32'd0);
        chk("mid_rst_flags", {29'd0, ovf, cout_1, cout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
        end
        send_chk("post_rst", 32'h0001_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h0001_0000, 1'b1, 1'b1, 1'b0);
        tick();
        chk("end_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined two's-complement adder/subtractor, successor of the 16-bit complement adder. It splits a WIDTH-bit add into STAGE_W-bit ripple slices, with one register stage per slice and the carry registered between slices. It sits between the operand-issue logic and the ALU result mux, and uses a valid/ready handshake so the downstream mux can apply backpressure. It keeps the existing carry-in semantics: cin or sign, selected by comp_e.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of STAGE_W, ≥ STAGE_W.
- STAGE_W, 16: bits added per pipeline stage; NSTG = WIDTH/STAGE_W = latency in cycles.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand transfer request.
- in_ready  out  1  block can accept operands this cycle.
- a, b  in  WIDTH  operands.
- cin  in  1  carry-in, used when comp_e=0.
- sign  in  1  1: b is inverted (subtract).
- comp_e  in  1  1: carry-in := sign (true two's-complement subtract); 0: carry-in := cin.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- s  out  WIDTH  sum/difference.
- cout  out  1  carry out of bit WIDTH-1.
- cout_1  out  1  carry into bit WIDTH-1.
- ovf  out  1  signed overflow = cout ^ cout_1.

## Operation
- Accept: in_valid && in_ready. Captured operand is xb = b ^ {WIDTH{sign}}, with c0 = comp_e ? sign : cin.
- Stage k (0..NSTG-1) computes bits [k*STAGE_W +: STAGE_W] of a + xb + carry, where carry is c0 for k=0 and the registered carry from stage k-1 otherwise.
- Upper operand slices are skewed through delay registers. Lower result slices are delayed alongside them, so all slices of one transaction leave together.
- cout_1 is the carry into the MSB inside the final stage. cout is that stage's carry-out.
- Each stage holds a valid bit. Bubbles are not collapsed.
- Global stall: en = !(out_valid && !out_ready). When en=0, every stage register, including valid bits, holds its value.
- in_ready = en (combinational from out_valid and out_ready). No combinational path from in_valid to in_ready.
- Transactions leave in acceptance order. None are dropped or duplicated.
- NSTG=1 degenerates to a single registered adder with latency 1.

## Timing
- Reset (async assert, sync release): all valid bits are 0. out_valid=0, s=0, cout=0, cout_1=0, ovf=0. in_ready=1 from the first cycle after release.
- Latency: an operand accepted at edge t gives out_valid=1 after edge t+NSTG−1, i.e. it is visible for NSTG cycles counting the accept cycle. Throughput is 1 per cycle while out_ready=1.
- s, cout, cout_1 and ovf are stable while out_valid && !out_ready.
- Simultaneous accept and output pop in a cycle with en=1: both occur and the pipeline advances.
- Reset mid-operation: all in-flight transactions are discarded. Outputs return to their reset values asynchronously.
- Wrap-around: unsigned overflow wraps modulo 2^WIDTH and is reported on cout only (unless saturation is compiled in).

## Configuration
- PIPELINED_ADDSUB_SAT_EN defined:
  - When ovf=1, s is replaced by the signed extreme: 0x7F..F if the transaction's a[WIDTH-1]=0, 0x80..0 if it is 1.
  - a's MSB is carried through the pipeline for this purpose.
  - cout, cout_1 and ovf still report raw values.
  - Unsigned results are not saturated.
- Not defined: s is always the raw modular result. No extra MSB pipeline bit is instantiated.

## Test plan
All scenarios use WIDTH=32, STAGE_W=16 (latency 2).
- Cross-slice carry: a=0x0000FFFF, b=1, sign=0, comp_e=0, cin=0 → s=0x00010000, cout=0, ovf=0, out_valid asserted 2 cycles after accept.
- Subtract: a=5, b=7, sign=1, comp_e=1 → s=0xFFFFFFFE, cout=0, ovf=0. Then a=7, b=5 → s=2, cout=1.
- comp_e=0 with sign=1, cin=0: a=10, b=3 → s=6 (a−b−1).
- Overflow: a=0x7FFFFFFF, b=1 add → ovf=1, cout_1=1, cout=0. s=0x80000000 without the macro, s=0x7FFFFFFF with PIPELINED_ADDSUB_SAT_EN.
- Backpressure: 4 back-to-back transactions, out_ready held low 3 cycles after the first result → in_ready=0 during the stall, the held result is stable, all 4 results emerge in order with no loss or duplication.
- Reset mid-flight: rst_n pulled low with 2 transactions in the pipe → out_valid=0 immediately. After release, out_valid stays 0 until a new accept plus 2 cycles.
